// File: rtl/ifq_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
`ifndef IFQ_PKG_SV
`define IFQ_PKG_SV
package ifq_pkg;
  localparam int W_IDATA = 32;
  localparam int W_ODATA = 128;
  localparam int INSTR_PER_LINE = 4;
  localparam int DEPTH_DEFAULT = 4;
  localparam logic [W_IDATA-1:0] RESET_PC_DEFAULT = 32'h0;

  // Byte address of the icache line that contains a.
  function automatic logic [W_IDATA-1:0] line_base(input logic [W_IDATA-1:0] a);
    return {a[W_IDATA-1:4], 4'b0000};
  endfunction
endpackage
`endif

// File: rtl/ifq_line_fifo.sv
// Line buffer for the fetch queue: DEPTH lines, extra-bit pointers, flush to empty.
module ifq_line_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [W_ODATA-1:0] wr_data,
  input  logic               rd_en,
  output logic [W_ODATA-1:0] rd_data,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [W_ODATA-1:0] mem_q [DEPTH];
  logic               do_wr;
  logic               do_rd;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;
  assign rd_data = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_wr) wptr_d = wptr_q + PW'(1);
      if (do_rd) rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is left uninitialised; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: requests icache lines, buffers them, and serves one
// instruction per cycle to dispatch; a branch redirect flushes and refetches.
module ifq
  import ifq_pkg::*;
#(
  parameter int                 DEPTH    = DEPTH_DEFAULT,
  parameter logic [W_IDATA-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic [W_IDATA-1:0] icache_pc_out,
  output logic               icache_rd_en,
  output logic               icache_abort,
  input  logic [W_ODATA-1:0] icache_dout,
  input  logic               icache_dout_valid,
  output logic [W_IDATA-1:0] dispatch_instr,
  output logic [W_IDATA-1:0] dispatch_pc,
  output logic               ifq_empty,
  input  logic               dispatch_rd_en,
  input  logic               branch_valid,
  input  logic [W_IDATA-1:0] branch_addr
);
  // Handshakes: a line is taken when icache_rd_en & icache_dout_valid (same
  // cycle as the request); an instruction is taken when dispatch_rd_en & ~ifq_empty.
  logic [W_IDATA-1:0] fetch_pc_q, fetch_pc_d;
  logic [W_IDATA-1:0] dispatch_pc_q, dispatch_pc_d;
  logic [1:0]         rd_off_q, rd_off_d;
  logic [W_ODATA-1:0] head_line;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               pop;
  logic               line_pop;

  assign icache_rd_en  = !full && !branch_valid;
  assign icache_abort  = branch_valid;
  assign icache_pc_out = line_base(fetch_pc_q);

  assign wr_en    = icache_rd_en && icache_dout_valid;
  assign pop      = dispatch_rd_en && !empty && !branch_valid;
  assign line_pop = pop && (rd_off_q == 2'd3);

  ifq_line_fifo #(.DEPTH(DEPTH)) u_line_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (branch_valid),
    .wr_en   (wr_en),
    .wr_data (icache_dout),
    .rd_en   (line_pop),
    .rd_data (head_line),
    .full    (full),
    .empty   (empty)
  );

  assign ifq_empty      = empty;
  assign dispatch_pc    = dispatch_pc_q;
  assign dispatch_instr = head_line[int'(rd_off_q) * W_IDATA +: W_IDATA];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    dispatch_pc_d = dispatch_pc_q;
    rd_off_d      = rd_off_q;
    if (branch_valid) begin
      // Fetch restarts at the target's line; dispatch skips the words before it.
      fetch_pc_d    = line_base(branch_addr);
      dispatch_pc_d = {branch_addr[W_IDATA-1:2], 2'b00};
      rd_off_d      = branch_addr[3:2];
    end else begin
      if (wr_en) fetch_pc_d = fetch_pc_q + W_IDATA'(16);
      if (pop) begin
        dispatch_pc_d = dispatch_pc_q + W_IDATA'(4);
        rd_off_d      = rd_off_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= line_base(RESET_PC);
      dispatch_pc_q <= {RESET_PC[W_IDATA-1:2], 2'b00};
      rd_off_q      <= RESET_PC[3:2];
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      dispatch_pc_q <= dispatch_pc_d;
      rd_off_q      <= rd_off_d;
    end
  end
endmodule

// File: tb/tb_ifq.sv
// Bench for ifq: directed vector table, random traffic against a queue-of-PCs
// model, plus hand-written full/throttle and mid-stream reset sequences.
module tb_ifq;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  icache_pc_out;
  logic         icache_rd_en;
  logic         icache_abort;
  logic [127:0] icache_dout;
  logic         icache_dout_valid = 1'b0;
  logic [31:0]  dispatch_instr;
  logic [31:0]  dispatch_pc;
  logic         ifq_empty;
  logic         dispatch_rd_en = 1'b0;
  logic         branch_valid = 1'b0;
  logic [31:0]  branch_addr = '0;
  logic [31:0]  base_w;

  always #5 clk = ~clk;

  ifq #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk               (clk),
    .reset             (reset),
    .icache_pc_out     (icache_pc_out),
    .icache_rd_en      (icache_rd_en),
    .icache_abort      (icache_abort),
    .icache_dout       (icache_dout),
    .icache_dout_valid (icache_dout_valid),
    .dispatch_instr    (dispatch_instr),
    .dispatch_pc       (dispatch_pc),
    .ifq_empty         (ifq_empty),
    .dispatch_rd_en    (dispatch_rd_en),
    .branch_valid      (branch_valid),
    .branch_addr       (branch_addr)
  );

  // Zero-latency icache: the word at byte address a holds a>>2.
  assign base_w      = icache_pc_out >> 2;
  assign icache_dout = {base_w + 32'd3, base_w + 32'd2, base_w + 32'd1, base_w};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of byte PCs of every instruction still buffered.
  logic [31:0] exp_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_dpc;
  int          m_skip;

  // Each buffered line holds exactly one word-3 entry until it is fully consumed.
  function automatic int m_lines();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][3:2] == 2'd3) n++;
    return n;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_fetch = 32'h0;
    m_dpc   = 32'h0;
    m_skip  = 0;
  endtask

  task automatic model_check();
    logic m_full;
    m_full = (m_lines() == DEPTH);
    check("m_rd_en", {31'b0, icache_rd_en}, {31'b0, !m_full && !branch_valid});
    check("m_abort", {31'b0, icache_abort}, {31'b0, branch_valid});
    check("m_pc_out", icache_pc_out, m_fetch);
    check("m_empty", {31'b0, ifq_empty}, {31'b0, exp_q.size() == 0});
    check("m_dpc", dispatch_pc, m_dpc);
    if (exp_q.size() > 0) check("m_instr", dispatch_instr, exp_q[0] >> 2);
  endtask

  task automatic model_tick();
    logic m_full;
    if (branch_valid) begin
      exp_q.delete();
      m_fetch = {branch_addr[31:4], 4'b0};
      m_skip  = int'(branch_addr[3:2]);
      m_dpc   = {branch_addr[31:2], 2'b0};
    end else begin
      m_full = (m_lines() == DEPTH);
      if (dispatch_rd_en && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        m_dpc = m_dpc + 32'd4;
      end
      if (!m_full && icache_dout_valid) begin
        for (int k = m_skip; k < 4; k++) exp_q.push_back(m_fetch + 32'(4 * k));
        m_skip  = 0;
        m_fetch = m_fetch + 32'd16;
      end
    end
  endtask

  task automatic drive(input logic rd, input logic br, input logic [31:0] ba, input logic dv);
    dispatch_rd_en    = rd;
    branch_valid      = br;
    branch_addr       = ba;
    icache_dout_valid = dv;
  endtask

  task automatic cycle(input logic rd, input logic br, input logic [31:0] ba, input logic dv);
    drive(rd, br, ba, dv);
    @(negedge clk);
    model_check();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_empty", {31'b0, ifq_empty}, 32'd1);
    check("rst_dpc", dispatch_pc, 32'h0);
    check("rst_pc_out", icache_pc_out, 32'h0);
    check("rst_rd_en", {31'b0, icache_rd_en}, 32'd1);
    check("rst_abort", {31'b0, icache_abort}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        br;
    logic [31:0] ba;
    logic        dv;
    logic        e_rd_en;
    logic        e_abort;
    logic [31:0] e_pc;
    logic        e_empty;
    logic [31:0] e_dpc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic br, input logic [31:0] ba,
                              input logic dv, input logic e_rd_en, input logic e_abort,
                              input logic [31:0] e_pc, input logic e_empty,
                              input logic [31:0] e_dpc, input logic [31:0] e_instr);
    vec_t v;
    v.rd = rd; v.br = br; v.ba = ba; v.dv = dv;
    v.e_rd_en = e_rd_en; v.e_abort = e_abort; v.e_pc = e_pc;
    v.e_empty = e_empty; v.e_dpc = e_dpc; v.e_instr = e_instr;
    return v;
  endfunction

  vec_t tbl[19];
  int   fetches;
  int   rdp;

  initial begin
    //          rd br  addr     dv  rd_en ab  pc_out   empty dpc      instr
    tbl[0]  = mk(0, 0, 32'h0,   1,  1,    0,  32'h00,  1,    32'h00,  32'h0);
    tbl[1]  = mk(0, 0, 32'h0,   1,  1,    0,  32'h10,  0,    32'h00,  32'd0);
    tbl[2]  = mk(0, 0, 32'h0,   1,  1,    0,  32'h20,  0,    32'h00,  32'd0);
    tbl[3]  = mk(0, 0, 32'h0,   1,  1,    0,  32'h30,  0,    32'h00,  32'd0);
    tbl[4]  = mk(0, 0, 32'h0,   1,  0,    0,  32'h40,  0,    32'h00,  32'd0);
    tbl[5]  = mk(1, 0, 32'h0,   1,  0,    0,  32'h40,  0,    32'h00,  32'd0);
    tbl[6]  = mk(1, 0, 32'h0,   1,  0,    0,  32'h40,  0,    32'h04,  32'd1);
    tbl[7]  = mk(1, 0, 32'h0,   1,  0,    0,  32'h40,  0,    32'h08,  32'd2);
    tbl[8]  = mk(1, 0, 32'h0,   1,  0,    0,  32'h40,  0,    32'h0C,  32'd3);
    tbl[9]  = mk(0, 0, 32'h0,   1,  1,    0,  32'h40,  0,    32'h10,  32'd4);
    tbl[10] = mk(1, 1, 32'h48,  1,  0,    1,  32'h50,  0,    32'h10,  32'd4);
    tbl[11] = mk(0, 0, 32'h0,   1,  1,    0,  32'h40,  1,    32'h48,  32'h0);
    tbl[12] = mk(1, 0, 32'h0,   1,  1,    0,  32'h50,  0,    32'h48,  32'd18);
    tbl[13] = mk(1, 0, 32'h0,   1,  1,    0,  32'h60,  0,    32'h4C,  32'd19);
    tbl[14] = mk(1, 0, 32'h0,   1,  1,    0,  32'h70,  0,    32'h50,  32'd20);
    tbl[15] = mk(1, 1, 32'h107, 1,  0,    1,  32'h80,  0,    32'h54,  32'd21);
    tbl[16] = mk(1, 0, 32'h0,   0,  1,    0,  32'h100, 1,    32'h104, 32'h0);
    tbl[17] = mk(1, 0, 32'h0,   1,  1,    0,  32'h100, 1,    32'h104, 32'h0);
    tbl[18] = mk(0, 0, 32'h0,   1,  1,    0,  32'h110, 0,    32'h104, 32'h41);

    #1;
    do_reset();

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rd, tbl[i].br, tbl[i].ba, tbl[i].dv);
      @(negedge clk);
      check($sformatf("t%0d_rd_en", i), {31'b0, icache_rd_en}, {31'b0, tbl[i].e_rd_en});
      check($sformatf("t%0d_abort", i), {31'b0, icache_abort}, {31'b0, tbl[i].e_abort});
      check($sformatf("t%0d_pc_out", i), icache_pc_out, tbl[i].e_pc);
      check($sformatf("t%0d_empty", i), {31'b0, ifq_empty}, {31'b0, tbl[i].e_empty});
      check($sformatf("t%0d_dpc", i), dispatch_pc, tbl[i].e_dpc);
      if (!tbl[i].e_empty) check($sformatf("t%0d_instr", i), dispatch_instr, tbl[i].e_instr);
      model_check();
      model_tick();
      @(posedge clk);
      #1;
    end

    // Full queue throttled by one pop every 4 cycles: one refill per line consumed.
    do_reset();
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    fetches = 0;
    for (int c = 0; c < 48; c++) begin
      drive((c % 4) == 0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      if (icache_rd_en) fetches++;
      model_check();
      model_tick();
      @(posedge clk);
      #1;
    end
    check("throttle_fetches", 32'(fetches), 32'd3);
    for (int c = 0; c < 24; c++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Random traffic with varying pop pressure and occasional redirects.
    for (int blk = 0; blk < 20; blk++) begin
      rdp = $urandom_range(0, 4);
      for (int c = 0; c < 80; c++) begin
        cycle($urandom_range(0, 3) < rdp,
              $urandom_range(0, 24) == 0,
              32'($urandom_range(0, 32'h3FF)),
              $urandom_range(0, 4) != 0);
      end
    end

    // Reset mid-stream: state clears asynchronously, then a pop while empty is ignored.
    for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_empty", {31'b0, ifq_empty}, 32'd1);
    check("async_rst_dpc", dispatch_pc, 32'h0);
    check("async_rst_pc_out", icache_pc_out, 32'h0);
    @(posedge clk);
    #1;
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("pop_empty_dpc", dispatch_pc, 32'h0);
    for (int c = 0; c < 8; c++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
